// File: rtl/uart_rx_if.sv
// Pop-side handshake between the UART receive FIFO and the core.
// The master drains bytes, the slave (uart_rx) presents the FIFO head.
interface uart_rx_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          rd_en;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic [CW-1:0] rx_count;

    modport master (
        output rd_en,
        input  rx_data,
        input  rx_empty,
        input  rx_count
    );

    modport slave (
        input  rd_en,
        output rx_data,
        output rx_empty,
        output rx_count
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a
// first-word-fall-through receive FIFO with sticky frame/overrun flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DEPTH        = 16
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       clr_err,
    uart_rx_if.slave   pop,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [DEPTH];

    logic rxs_c;
    logic push_c;
    logic ferr_set_c;
    logic pop_ok_c;
    logic full_c;
    logic push_ok_c;
    logic ovr_set_c;

    assign rxs_c = sync_q[1];

    // Receive FSM: START checks the start bit at half period, later samples
    // land one full period apart, i.e. in the middle of each bit.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rxs_c) begin
                    state_d = S_START;
                    bcnt_d  = '0;
                end
            end
            S_START: begin
                if (bcnt_q == HALF_LAST) begin
                    bcnt_d = '0;
                    if (!rxs_c) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d  = '0;
                    shift_d = {rxs_c, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d = '0;
                    if (rxs_c) begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_d    = S_BREAK;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_BREAK: begin
                if (rxs_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                bcnt_d  = '0;
            end
        endcase
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot for a push.
    always_comb begin
        pop_ok_c  = pop.rd_en & ~empty_q;
        full_c    = (count_q == FULL_CNT);
        push_ok_c = push_c & (~full_c | pop_ok_c);
        ovr_set_c = push_c & ~push_ok_c;

        wr_ptr_d = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_d = count_q - CW'(1);
        end
        empty_d = (count_d == '0);

        frame_err_d = ferr_set_c | (frame_err_q & ~clr_err);
        overrun_d   = ovr_set_c  | (overrun_q   & ~clr_err);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rxd};
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk_100MHz) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign pop.rx_data  = mem_q[rd_ptr_q];
    assign pop.rx_empty = empty_q;
    assign pop.rx_count = count_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx, checked against a queue-based
// model of the receive FIFO and the sticky error flags.
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rxd     = 1'b1;
    logic clr_err = 1'b0;
    logic busy;
    logic frame_err;
    logic overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] model[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;

    uart_rx_if #(.DEPTH(DEPTH)) pif ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .clr_err    (clr_err),
        .pop        (pif.slave),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of what the receiver should have done with one complete frame.
    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                   exp_ferr = 1'b1;
        else if (model.size() < DEPTH)  model.push_back(b);
        else                            exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(pif.rx_count), 32'(model.size()));
        check({tag, ".empty"}, 32'(pif.rx_empty), 32'(model.size() == 0));
        check({tag, ".ferr"},  32'(frame_err),    32'(exp_ferr));
        check({tag, ".ovr"},   32'(overrun),      32'(exp_ovr));
        check({tag, ".busy"},  32'(busy),         32'd0);
        if (model.size() != 0) check({tag, ".head"}, 32'(pif.rx_data), 32'(model[0]));
    endtask

    task automatic pop_one(input string tag);
        check({tag, ".pophead"}, 32'(pif.rx_data), 32'(model[0]));
        pif.rd_en = 1'b1;
        tick();
        pif.rd_en = 1'b0;
        void'(model.pop_front());
        check_state(tag);
    endtask

    task automatic pop_all(input string tag);
        while (model.size() != 0) pop_one(tag);
    endtask

    // One 8N1 frame, 10 bit times. Optionally pops in the stop-sample cycle
    // (clock edge 155 after the start-bit drive) or pulls reset mid-frame.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                              input bit pop_at_stop, input int abort_at);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            rxd       = fr[i / CPB];
            pif.rd_en = pop_at_stop && (i == 154);
            if (i == abort_at) begin
                reset_n = 1'b0;
                #2;
                check("rst.busy",  32'(busy),         32'd0);
                check("rst.empty", 32'(pif.rx_empty), 32'd1);
                check("rst.count", 32'(pif.rx_count), 32'd0);
                check("rst.ferr",  32'(frame_err),    32'd0);
                check("rst.ovr",   32'(overrun),      32'd0);
                break;
            end
            if (i == 80) check("busy_mid", 32'(busy), 32'd1);
            tick();
        end
        pif.rd_en = 1'b0;
    endtask

    task automatic rx_good(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0, -1);
        model_rx(b, 1'b1);
        idle(4);
    endtask

    initial begin
        logic [7:0] b;
        pif.rd_en = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        idle(8);
        check_state("reset");

        // Two back-to-back frames.
        rx_good(8'hA5);
        rx_good(8'h3C);
        check_state("two");
        pop_all("two");

        // Short low glitch on an idle line.
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        tick();
        check("glitch.busy", 32'(busy), 32'd1);
        idle(CPB * 2);
        check_state("glitch");

        // Framing error, line held low; clearing during the break must stick.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        model_rx(8'h55, 1'b0);
        repeat (CPB) tick();
        check("brk.ferr",  32'(frame_err),    32'd1);
        check("brk.busy",  32'(busy),         32'd1);
        check("brk.count", 32'(pif.rx_count), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err  = 1'b0;
        exp_ferr = 1'b0;
        repeat (2 * CPB) tick();
        check("brk.once", 32'(frame_err), 32'd0);
        idle(CPB);
        check_state("brk.end");
        rx_good(8'h81);
        check_state("after_brk");
        pop_all("after_brk");

        // Randomized traffic with random pops between frames.
        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom);
            rx_good(b);
            idle($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1 && model.size() != 0) pop_one("rand");
        end
        check_state("rand.end");
        pop_all("rand.drain");

        // Fill to DEPTH, then overrun.
        for (int v = 0; v < DEPTH; v++) rx_good(8'(v));
        check_state("full");
        rx_good(8'hFF);
        check_state("ovr");
        pop_all("ovr.drain");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        check_state("ovr.clr");

        // Full FIFO with a pop landing in the stop-sample cycle.
        for (int v = 0; v < DEPTH; v++) rx_good(8'($urandom));
        check_state("full2");
        send_frame(8'hEE, 1'b1, 1'b1, -1);
        void'(model.pop_front());
        model.push_back(8'hEE);
        idle(4);
        check_state("popstop");
        pop_all("popstop.drain");

        // Reset mid-frame with data and a flag pending.
        rx_good(8'h11);
        send_frame(8'h00, 1'b0, 1'b0, -1);
        model_rx(8'h00, 1'b0);
        idle(CPB);
        check_state("prerst");
        send_frame(8'h7E, 1'b1, 1'b0, 5 * CPB + CPB / 2);
        model.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        rxd = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        idle(CPB);
        check_state("postrst");
        rx_good(8'h7E);
        check_state("rst.7e");
        pop_all("rst.drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the core's UART link, the counterpart of the transmit path: it takes the 8N1 line (idle-high, LSB first) and decodes it into bytes. The bytes land in an on-chip receive FIFO, which the core drains through a pop handshake. Line-error conditions are reported through sticky flags. Default timing matches the transmit side: 9600 baud derived from the 100 MHz system clock.

## Interface
- CLKS_PER_BIT, 10416, system clocks per bit period (100 MHz / 9600); must be ≥ 8.
- DEPTH, 16, receive FIFO entries; power of two, ≥ 2.
- clk_100MHz  in  1  system clock; every flop is rising-edge on it.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial line, asynchronous to clk_100MHz; idle high.
- rd_en  in  1  pop request; ignored while rx_empty=1.
- clr_err  in  1  clears both sticky error flags.
- rx_data  out  8  FIFO head byte (first-word fall-through); valid only while rx_empty=0.
- rx_empty  out  1  FIFO empty.
- rx_count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- busy  out  1  high when the FSM is in any state other than IDLE.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte received while FIFO full.

## Operation
- Synchronizer: 2-flop chain on rxd, both flops reset to 1. The FSM sees only the synchronized value, rxs.
- Bit counter bcnt: 0..CLKS_PER_BIT-1. Data-bit index: 0..7. Shift register: 8 bits.
- IDLE: rxs=0 → START, bcnt←0.
- START: when bcnt = CLKS_PER_BIT/2-1 (integer divide), sample rxs.
  - 0 → DATA, bcnt←0, index←0.
  - 1 → IDLE; the event is a glitch, no flag.
- DATA: when bcnt = CLKS_PER_BIT-1, sample rxs into shift[7] and shift right; bcnt←0.
  - After index 7 → STOP; otherwise index+1.
  - Result: the first received bit ends in shift[0].
- STOP: when bcnt = CLKS_PER_BIT-1, sample rxs.
  - 1 → push shift into FIFO → IDLE.
  - 0 → frame_err←1, byte discarded → BREAK.
- BREAK: wait for rxs=1 → IDLE. A held-low line therefore produces exactly one frame_err and no further bytes.
- FIFO:
  - DEPTH×8 register array with write/read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - rx_count is maintained separately.
  - rx_empty = (rx_count==0); full = (rx_count==DEPTH).
  - Push is accepted if not full, or if a valid pop (rd_en & !rx_empty) occurs in the same cycle.
  - A push that is not accepted drops the byte and sets overrun←1. FIFO contents are unchanged.
  - Simultaneous accepted push and valid pop: rx_count unchanged, both pointers advance.
  - Pop on empty: no effect, pointers unchanged.
- clr_err=1 clears frame_err and overrun. If an error event occurs in the same cycle, the set wins.
- Reset values: FSM=IDLE, bcnt=0, shift=0, pointers=0, rx_count=0, rx_empty=1, busy=0, frame_err=0, overrun=0, rx_data=mem[0] (content undefined).
- Reset mid-frame aborts the frame immediately; no push, no flag.

## Timing
- rxd fall to START entry: 3 clocks (2 synchronizer clocks + 1 edge detect).
- Sampling points after START entry: start bit at CLKS_PER_BIT/2 clocks. Each data bit and the stop bit follow at further multiples of CLKS_PER_BIT, i.e. at mid-bit.
- Push happens in the stop-sample cycle. rx_empty falls and rx_data is valid on the next clock edge.
- Pop: rx_data shows the next entry one clock after the rd_en edge. rx_count updates on the same edge.
- busy is asserted from START entry through the stop-sample cycle (or through the end of BREAK).
- frame_err and overrun rise one clock after the stop-sample edge.
- Tolerates ±4% baud mismatch per frame.

## Test plan
- CLKS_PER_BIT=16: send 0xA5 then 0x3C as 8N1 frames → two pushes; rx_data=0xA5, pop → 0x3C, then rx_empty=1; no flags set.
- 4-clock low glitch on idle rxd → FSM returns to IDLE from START; no push, frame_err=0.
- Frame 0x55 with the stop bit forced low, line held low for 3 bit times → frame_err=1 exactly once, rx_count=0. clr_err → 0. Next valid frame 0x81 is received correctly.
- Fill FIFO with DEPTH frames 0x00..0x0F, send 0xFF with no pops → overrun=1, rx_count=16, contents 0x00..0x0F intact. Pop all → 0x00..0x0F in order, pointer wrap verified.
- FIFO full and rd_en asserted in the stop-sample cycle of 0xEE → no overrun, rx_count stays 16, 0xEE is the last entry.
- Assert reset_n low during data bit 4 → busy=0 and all outputs at reset values asynchronously. After release, frame 0x7E is received correctly.
